// File: rtl/grant_lock_requester.sv
// Requester-side companion to the shared arbiter: requests on behalf of clients, locks onto the
// granted client for a whole packet and forwards its flits under credit-based flow control.
module grant_lock_requester #(
  parameter int unsigned NUM_REQS     = 3,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = 4,
  parameter int unsigned CREDIT_DEPTH = 4,
  localparam int unsigned CW          = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic [NUM_REQS-1:0]            arb_requests,
  input  logic [NUM_REQS-1:0]            arb_grants,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_tail,
  output logic [NUM_REQS-1:0]            out_owner,
  input  logic                           credit_return,
  output logic [CW-1:0]                  credits,
  output logic                           busy,
  output logic                           err
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  localparam logic [CW-1:0] CredMax = CW'(CREDIT_DEPTH);

  state_e                state_q, state_d;
  logic [NUM_REQS-1:0]   owner_q, owner_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic                  err_q, err_d;

  logic                  cred_nz;
  logic                  xfer;
  logic                  grant_subset;
  logic [LEN_WIDTH-1:0]  grant_len;
  logic [DATA_WIDTH-1:0] owner_data;

  assign cred_nz      = (cred_q != '0);
  assign grant_subset = ((arb_grants & ~arb_requests) == '0);
  assign xfer         = (state_q == StXfer) && (|(req_valid & owner_q)) && cred_nz;

  // One-hot select muxes; the OR-reduction is only meaningful for a one-hot select.
  always_comb begin
    grant_len  = '0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (arb_grants[i]) grant_len = grant_len | req_len[i*LEN_WIDTH +: LEN_WIDTH];
      if (owner_q[i]) owner_data = owner_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Requests are held off while reset is asserted so every output reads 0 except credits.
  assign arb_requests = ((state_q == StIdle) && cred_nz && reset) ? req_valid : '0;
  assign req_ready    = xfer ? owner_q : '0;
  assign out_valid    = xfer;
  assign out_data     = xfer ? owner_data : '0;
  assign out_tail     = xfer && (rem_q == LEN_WIDTH'(1));
  assign out_owner    = owner_q;
  assign credits      = cred_q;
  assign busy         = (state_q == StXfer);
  assign err          = err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rem_d   = rem_q;
    cred_d  = cred_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (arb_grants != '0) begin
          if ($onehot(arb_grants) && grant_subset) begin
            owner_d = arb_grants;
            rem_d   = (grant_len == '0) ? LEN_WIDTH'(1) : grant_len;
            state_d = StXfer;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StXfer: begin
        if (xfer) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = StIdle;
            owner_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (xfer && !credit_return) begin
      cred_d = cred_q - CW'(1);
    end else if (!xfer && credit_return) begin
      // A return with every slot already free is a downstream protocol error.
      if (cred_q == CredMax) err_d = 1'b1;
      else cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      rem_q   <= '0;
      cred_q  <= CredMax;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/grant_lock_requester.md
Name: grant_lock_requester

Overview:
- Requester-side companion to the shared arbiter.
- Collects packet requests from NUM_REQS clients and drives the arbiter's request vector. It samples the one-hot grant vector and locks the output to the winner for the full packet.
- Forwards the winner's flits downstream under credit-based flow control.
- Sits between input-port VC buffers and the switch or output link, with an arbiter_top instance between its arb_requests and arb_grants ports.

Parameters:
NUM_REQS, 3, number of requesting clients (>=2)
DATA_WIDTH, 32, flit payload width
LEN_WIDTH, 4, width of per-client packet length field
CREDIT_DEPTH, 4, downstream buffer slots; credit counter reset value (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQS  client i has a flit of a pending/active packet
req_len  input  NUM_REQS*LEN_WIDTH  client i packet length in flits, slice i at [i*LEN_WIDTH +: LEN_WIDTH]; sampled at grant
req_data  input  NUM_REQS*DATA_WIDTH  client i current flit payload
req_ready  output  NUM_REQS  one-hot; flit of client i consumed this cycle
arb_requests  output  NUM_REQS  request vector to arbiter
arb_grants  input  NUM_REQS  grant vector from arbiter, same-cycle response to arb_requests
out_valid  output  1  flit valid downstream
out_data  output  DATA_WIDTH  flit payload
out_tail  output  1  flit is last of packet
out_owner  output  NUM_REQS  one-hot owner of current packet; 0 when idle
credit_return  input  1  downstream freed one slot (1-cycle pulse)
credits  output  clog2(CREDIT_DEPTH+1)  current credit count
busy  output  1  state is XFER
err  output  1  sticky protocol error flag

Behaviour:
- States: IDLE and XFER.
- Reset (asynchronous assert, any time including mid-packet):
  - state=IDLE, owner=0, remaining=0, credits=CREDIT_DEPTH, err=0.
  - All outputs 0 except credits.
  - In-flight packet is abandoned.
- IDLE:
  - arb_requests = req_valid when credits!=0, else 0.
  - req_ready=0, out_valid=0.
- Grant sampling at the clock edge in IDLE:
  - If arb_grants is exactly one-hot and a subset of arb_requests: latch owner=arb_grants and remaining=req_len[owner], with len 0 treated as 1. Next state XFER.
  - If arb_grants is nonzero but not one-hot, or not a subset of arb_requests: ignore it, stay IDLE, set err.
  - If arb_grants=0: stay IDLE.
- XFER:
  - arb_requests=0, so the arbiter sees no requests and its state does not advance.
  - A flit transfers in a cycle when req_valid[owner] && credits!=0. That cycle: req_ready=owner, out_valid=1, out_data=req_data[owner] (combinational mux), out_tail=(remaining==1).
  - On each transfer: remaining decrements and credits decrements.
  - The transfer with out_tail=1 returns the state to IDLE at the next edge, with owner cleared.
  - No transfer (client bubble or zero credits): stall; all values hold and req_ready=0.
- Latency: a grant sampled at edge T allows the first flit at cycle T+1 at the earliest. Back-to-back single-flit packets take 2 cycles each. No combinational path from arb_grants to req_ready or out_*.
- Credits:
  - Transfer only: -1.
  - credit_return only: +1.
  - Both in the same cycle: unchanged.
  - credit_return at credits==CREDIT_DEPTH with no transfer: count saturates and err is set.
  - credits==0 is never decremented, since a transfer requires credits!=0.
- Owner's req_valid dropping mid-packet: stall only, not an error; lock is held until the tail flit.
- Non-owner clients: req_ready held 0 during XFER; their req_valid is ignored.
- err: cleared only by reset.

Test Plan:
- Reset release, credits=4, req_valid=3'b010, len=3, arbiter grants 010 -> busy next cycle; 3 flits with out_owner=010 and out_tail on the 3rd only; credits 4->1; back to IDLE.
- Two clients 3'b101 under round-robin arbiter, len=1 each, credit_return each flit cycle -> alternating owners 001/100, one flit per 2 cycles, credits stay 4.
- CREDIT_DEPTH=2, len=4, no returns until cycle 5 -> 2 flits then stall with out_valid=0, credits=0; a credit_return pulse -> 1 more flit per pulse, tail on 4th.
- credit_return coincident with a transfer at credits=1 -> credits stays 1. Return pulse with credits=4 and idle -> credits stays 4, err=1.
- Force arb_grants=3'b011 -> no lock, busy=0, err=1. Force grant 100 with req_valid=010 -> err=1, stays IDLE.
- Assert reset mid-packet after 2 of 5 flits -> outputs 0 immediately, credits=CREDIT_DEPTH. After release, a new grant starts a fresh packet with full len.
